// File: rtl/gate_sweep_ctrl.sv
// Exhaustive truth-table sweep of a small combinational gate: drives every
// stimulus vector, waits to settle, compares against a latched expectation.
module gate_sweep_ctrl #(
    parameter int N_IN          = 2,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [2**N_IN-1:0]   exp_table,
    input  logic                 gate_y,
    output logic [N_IN-1:0]      gate_in,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [N_IN:0]        err_count,
    output logic [N_IN-1:0]      fail_idx
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        CHECK,
        DONE
    } state_t;

    localparam logic [3:0]      SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
    localparam logic [N_IN:0]   ERR_ONE     = (N_IN+1)'(1);
    localparam logic [N_IN-1:0] GIN_ONE     = N_IN'(1);

    state_t              r_state;
    state_t              w_next;
    logic [3:0]          r_cnt;
    logic [2**N_IN-1:0]  r_exp;
    logic [N_IN-1:0]     r_gate_in;
    logic [N_IN:0]       r_err;
    logic [N_IN-1:0]     r_fail;
    logic                r_pass;
    logic                w_mismatch;
    logic                w_last_vec;
    logic                w_settled;

    assign w_mismatch = (gate_y != r_exp[r_gate_in]);
    assign w_last_vec = (r_gate_in == '1);
    assign w_settled  = (r_cnt == SETTLE_LAST);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = SETTLE;
            SETTLE: begin
                if (abort)          w_next = IDLE;
                else if (w_settled) w_next = CHECK;
            end
            CHECK: begin
                if (abort)           w_next = IDLE;
                else if (w_last_vec) w_next = DONE;
                else                 w_next = SETTLE;
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_exp     <= '0;
            r_gate_in <= '0;
            r_err     <= '0;
            r_fail    <= '0;
            r_pass    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_exp     <= exp_table;
                        r_gate_in <= '0;
                        r_err     <= '0;
                        r_fail    <= '0;
                        r_pass    <= 1'b0;
                        r_cnt     <= '0;
                    end
                end
                SETTLE: begin
                    if (abort)           r_pass <= 1'b0;
                    else if (!w_settled) r_cnt  <= r_cnt + 4'd1;
                end
                CHECK: begin
                    if (abort) begin
                        r_pass <= 1'b0;
                    end else begin
                        if (w_mismatch) begin
                            r_err <= r_err + ERR_ONE;
                            if (r_err == '0) r_fail <= r_gate_in;
                        end
                        // pass must include this final comparison, so use the pre-update count
                        if (w_last_vec) begin
                            r_pass <= (r_err == '0) && !w_mismatch;
                        end else begin
                            r_gate_in <= r_gate_in + GIN_ONE;
                            r_cnt     <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign gate_in   = r_gate_in;
    assign busy      = (r_state == SETTLE) || (r_state == CHECK);
    assign done      = (r_state == DONE);
    assign pass      = r_pass;
    assign err_count = r_err;
    assign fail_idx  = r_fail;

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Directed bench for gate_sweep_ctrl: default instance plus a SETTLE_CYCLES=1 instance.
module tb_gate_sweep_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic       rst, start, abort, gate_y;
    logic [3:0] exp_table;
    logic [1:0] gmode;
    logic [1:0] gate_in, fail_idx;
    logic       busy, done, pass;
    logic [2:0] err_count;

    logic       rst1, start1, abort1, gate_y1;
    logic [3:0] exp1;
    logic [1:0] gmode1;
    logic [1:0] gate_in1, fail_idx1;
    logic       busy1, done1, pass1;
    logic [2:0] err1;

    // gmode: 0 = good inverter on gate_in[0], 1 = stuck-at-0, 2 = stuck-at-1
    assign gate_y  = (gmode  == 2'd0) ? ~gate_in[0]  : (gmode  == 2'd1) ? 1'b0 : 1'b1;
    assign gate_y1 = (gmode1 == 2'd0) ? ~gate_in1[0] : (gmode1 == 2'd1) ? 1'b0 : 1'b1;

    gate_sweep_ctrl #(.N_IN(2), .SETTLE_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .exp_table(exp_table),
        .gate_y(gate_y), .gate_in(gate_in), .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .fail_idx(fail_idx)
    );

    gate_sweep_ctrl #(.N_IN(2), .SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst1), .start(start1), .abort(abort1), .exp_table(exp1),
        .gate_y(gate_y1), .gate_in(gate_in1), .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .fail_idx(fail_idx1)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; rst1 = 1'b1; start = 1'b0; start1 = 1'b0; abort = 1'b0; abort1 = 1'b0;
        exp_table = 4'b0101; exp1 = 4'b0101; gmode = 2'd0; gmode1 = 2'd0;
        tick; tick;
        checks++;
        if ({gate_in, busy, done, pass, err_count, fail_idx} !== 10'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%b want=0", {gate_in, busy, done, pass, err_count, fail_idx});
        end
        checks++;
        if ({gate_in1, busy1, done1, pass1, err1, fail_idx1} !== 10'd0) begin
            failures++;
            $display("FAIL reset_outputs_s1 got=%b want=0", {gate_in1, busy1, done1, pass1, err1, fail_idx1});
        end
        start = 1'b1;
        tick;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_start_ignored busy=%b want=0", busy);
        end
        rst = 1'b0; rst1 = 1'b0;
        tick;
        checks++;
        if (busy !== 1'b1 || gate_in !== 2'd0) begin
            failures++;
            $display("FAIL reset_first_start busy=%b gate_in=%0d want 1/0", busy, gate_in);
        end
        start = 1'b0;
        repeat (4) tick;
        rst = 1'b1; abort = 1'b1;
        tick;
        checks++;
        if ({gate_in, busy, done, pass, err_count, fail_idx} !== 10'd0) begin
            failures++;
            $display("FAIL reset_mid_sweep got=%b want=0", {gate_in, busy, done, pass, err_count, fail_idx});
        end
        tick;
        rst = 1'b0; abort = 1'b0;
        tick;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_stays_idle busy=%b done=%b want 0/0", busy, done);
        end
    endtask

    task automatic test_good_not;
        logic [1:0] eg;
        gmode = 2'd0; exp_table = 4'b0101; start = 1'b1;
        tick;
        start = 1'b0;
        for (int k = 0; k < 12; k++) begin
            eg = 2'(k / 3);
            checks++;
            if (busy !== 1'b1 || done !== 1'b0 || gate_in !== eg) begin
                failures++;
                $display("FAIL good_step edge=%0d busy=%b done=%b gate_in=%0d want 1/0/%0d",
                         k, busy, done, gate_in, eg);
            end
            tick;
        end
        checks++;
        if ({busy, done, pass, err_count, fail_idx, gate_in} !== {1'b0, 1'b1, 1'b1, 3'd0, 2'd0, 2'd3}) begin
            failures++;
            $display("FAIL good_done busy=%b done=%b pass=%b err=%0d fail=%0d gate_in=%0d want 0/1/1/0/0/3",
                     busy, done, pass, err_count, fail_idx, gate_in);
        end
        tick;
        checks++;
        if ({busy, done, pass, gate_in} !== {1'b0, 1'b0, 1'b1, 2'd3}) begin
            failures++;
            $display("FAIL good_hold busy=%b done=%b pass=%b gate_in=%0d want 0/0/1/3",
                     busy, done, pass, gate_in);
        end
    endtask

    task automatic test_stuck0;
        gmode = 2'd1; exp_table = 4'b0101; start = 1'b1;
        tick;
        start = 1'b0;
        checks++;
        if (pass !== 1'b0 || err_count !== 3'd0 || gate_in !== 2'd0) begin
            failures++;
            $display("FAIL s0_start_clear pass=%b err=%0d gate_in=%0d want 0/0/0", pass, err_count, gate_in);
        end
        for (int k = 1; k <= 12; k++) begin
            tick;
            if (k == 3) begin
                checks++;
                if (err_count !== 3'd1 || fail_idx !== 2'd0) begin
                    failures++;
                    $display("FAIL s0_first_err err=%0d fail=%0d want 1/0", err_count, fail_idx);
                end
            end
            if (k == 9) begin
                checks++;
                if (err_count !== 3'd2) begin
                    failures++;
                    $display("FAIL s0_second_err err=%0d want 2", err_count);
                end
            end
            if (k < 12 && done !== 1'b0) begin
                checks++;
                failures++;
                $display("FAIL s0_early_done edge=%0d done=%b want 0", k, done);
            end
        end
        checks++;
        if ({done, pass, err_count, fail_idx} !== {1'b1, 1'b0, 3'd2, 2'd0}) begin
            failures++;
            $display("FAIL s0_done done=%b pass=%b err=%0d fail=%0d want 1/0/2/0",
                     done, pass, err_count, fail_idx);
        end
        tick;
    endtask

    task automatic test_first_fail;
        gmode = 2'd2; exp_table = 4'b0101; start = 1'b1;
        tick;
        start = 1'b0; exp_table = 4'b1010;
        for (int k = 1; k <= 12; k++) begin
            tick;
            if (k == 6) begin
                checks++;
                if (err_count !== 3'd1 || fail_idx !== 2'd1) begin
                    failures++;
                    $display("FAIL s1_first_err err=%0d fail=%0d want 1/1", err_count, fail_idx);
                end
            end
        end
        checks++;
        if ({done, pass, err_count, fail_idx} !== {1'b1, 1'b0, 3'd2, 2'd1}) begin
            failures++;
            $display("FAIL s1_done done=%b pass=%b err=%0d fail=%0d want 1/0/2/1",
                     done, pass, err_count, fail_idx);
        end
        tick;
        exp_table = 4'b0101;
    endtask

    task automatic test_all_fail;
        gmode = 2'd0; exp_table = 4'b1010; start = 1'b1;
        tick;
        start = 1'b0;
        repeat (12) tick;
        checks++;
        if ({done, pass, err_count, fail_idx} !== {1'b1, 1'b0, 3'd4, 2'd0}) begin
            failures++;
            $display("FAIL allfail_done done=%b pass=%b err=%0d fail=%0d want 1/0/4/0",
                     done, pass, err_count, fail_idx);
        end
        tick;
        exp_table = 4'b0101;
    endtask

    task automatic test_back_to_back;
        logic [1:0] eg;
        logic [1:0] wbd;
        gmode = 2'd0; exp_table = 4'b0101; start = 1'b1;
        tick;
        for (int k = 1; k <= 26; k++) begin
            tick;
            eg = 2'(((k < 13) ? k : k - 14) / 3);
            if (k == 12 || k == 26) wbd = 2'b01;
            else if (k == 13)       wbd = 2'b00;
            else                    wbd = 2'b10;
            checks++;
            if ({busy, done} !== wbd || (wbd == 2'b10 && gate_in !== eg)) begin
                failures++;
                $display("FAIL b2b_step edge=%0d busy/done=%b gate_in=%0d want %b/%0d",
                         k, {busy, done}, gate_in, wbd, eg);
            end
            if (k == 14) begin
                checks++;
                if (pass !== 1'b0) begin
                    failures++;
                    $display("FAIL b2b_pass_clear pass=%b want 0", pass);
                end
            end
            if (k == 26) begin
                checks++;
                if (pass !== 1'b1) begin
                    failures++;
                    $display("FAIL b2b_pass pass=%b want 1", pass);
                end
            end
        end
        start = 1'b0;
        tick; tick;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL b2b_stop busy=%b done=%b want 0/0", busy, done);
        end
    endtask

    task automatic test_abort;
        logic [1:0] eg;
        gmode = 2'd1; exp_table = 4'b0101; start = 1'b1;
        tick;
        start = 1'b0;
        repeat (6) tick;
        abort = 1'b1;
        tick;
        abort = 1'b0;
        checks++;
        if ({busy, done, pass} !== 3'b000) begin
            failures++;
            $display("FAIL abort_settle busy/done/pass=%b want 000", {busy, done, pass});
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (busy !== 1'b0 || done !== 1'b0) begin
                failures++;
                $display("FAIL abort_quiet cyc=%0d busy=%b done=%b want 0/0", k, busy, done);
            end
            tick;
        end
        start = 1'b1; abort = 1'b1;
        tick;
        start = 1'b0; abort = 1'b0;
        checks++;
        if ({busy, gate_in, err_count, fail_idx} !== {1'b1, 2'd0, 3'd0, 2'd0}) begin
            failures++;
            $display("FAIL abort_restart busy=%b gate_in=%0d err=%0d fail=%0d want 1/0/0/0",
                     busy, gate_in, err_count, fail_idx);
        end
        tick; tick;
        abort = 1'b1;
        tick;
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || err_count !== 3'd0) begin
            failures++;
            $display("FAIL abort_check busy=%b done=%b err=%0d want 0/0/0", busy, done, err_count);
        end
        gmode = 2'd0; start = 1'b1;
        tick;
        start = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick;
            eg = 2'(k / 3);
            if (k < 12) begin
                checks++;
                if (busy !== 1'b1 || gate_in !== eg) begin
                    failures++;
                    $display("FAIL abort_rerun edge=%0d busy=%b gate_in=%0d want 1/%0d", k, busy, gate_in, eg);
                end
            end
        end
        checks++;
        if ({done, pass, err_count} !== {1'b1, 1'b1, 3'd0}) begin
            failures++;
            $display("FAIL abort_rerun_done done=%b pass=%b err=%0d want 1/1/0", done, pass, err_count);
        end
        abort = 1'b1;
        tick;
        abort = 1'b0;
        checks++;
        if ({busy, done, pass} !== 3'b001) begin
            failures++;
            $display("FAIL abort_in_done busy/done/pass=%b want 001", {busy, done, pass});
        end
    endtask

    task automatic test_rst_mid_s1;
        logic [1:0] eg;
        gmode1 = 2'd1; exp1 = 4'b1000; start1 = 1'b1;
        tick;
        start1 = 1'b0;
        repeat (7) tick;
        checks++;
        if (busy1 !== 1'b1 || gate_in1 !== 2'd3 || err1 !== 3'd0) begin
            failures++;
            $display("FAIL s1rst_pre busy=%b gate_in=%0d err=%0d want 1/3/0", busy1, gate_in1, err1);
        end
        rst1 = 1'b1;
        tick;
        rst1 = 1'b0;
        checks++;
        if ({gate_in1, busy1, done1, pass1, err1, fail_idx1} !== 10'd0) begin
            failures++;
            $display("FAIL s1rst_cleared got=%b want=0", {gate_in1, busy1, done1, pass1, err1, fail_idx1});
        end
        tick;
        checks++;
        if (busy1 !== 1'b0 || done1 !== 1'b0) begin
            failures++;
            $display("FAIL s1rst_no_done busy=%b done=%b want 0/0", busy1, done1);
        end
        gmode1 = 2'd0; exp1 = 4'b0101; start1 = 1'b1;
        tick;
        start1 = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick;
            eg = 2'(k / 2);
            if (k < 8) begin
                checks++;
                if (busy1 !== 1'b1 || done1 !== 1'b0 || gate_in1 !== eg) begin
                    failures++;
                    $display("FAIL s1run_step edge=%0d busy=%b done=%b gate_in=%0d want 1/0/%0d",
                             k, busy1, done1, gate_in1, eg);
                end
            end
        end
        checks++;
        if ({done1, busy1, pass1, err1} !== {1'b1, 1'b0, 1'b1, 3'd0}) begin
            failures++;
            $display("FAIL s1run_done done=%b busy=%b pass=%b err=%0d want 1/0/1/0",
                     done1, busy1, pass1, err1);
        end
    endtask

    initial begin
        test_reset;
        test_good_not;
        test_stuck0;
        test_first_fail;
        test_all_fail;
        test_back_to_back;
        test_abort;
        test_rst_mid_s1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gate_sweep_ctrl.md
GATE_SWEEP_CTRL -- requirements
Module: gate_sweep_ctrl

Interface
REQ-001 Parameters SHALL be, one per line:
  N_IN  2  width of stimulus vector driven to the gate under test (legal range 1..4).
  SETTLE_CYCLES  2  cycles each vector is held before the output is sampled (legal range 1..15).
REQ-002 Ports SHALL be, one per line:
  clk  in  1  single clock; all logic updates on its rising edge.
  rst  in  1  synchronous, active-high reset.
  start  in  1  request a sweep; sampled only in IDLE.
  abort  in  1  terminate a running sweep.
  exp_table  in  2**N_IN  expected gate output; bit i corresponds to stimulus vector i.
  gate_y  in  1  output of gate under test.
  gate_in  out  N_IN  registered stimulus to gate under test; bit 0 drives the first gate input.
  busy  out  1  high while a sweep is running.
  done  out  1  one-cycle pulse when a sweep completes.
  pass  out  1  result of last completed sweep.
  err_count  out  N_IN+1  mismatches in current or last sweep.
  fail_idx  out  N_IN  first mismatching vector index.
REQ-003 Clocking SHALL be one clock with a synchronous, active-high reset named rst; there SHALL be no other clock or asynchronous input path.

Function
REQ-004 FSM SHALL have exactly the states IDLE, SETTLE, CHECK and DONE.
REQ-005 IDLE with start=1 SHALL, at that edge: latch exp_table, set gate_in=0, clear err_count and fail_idx, clear pass, set busy=1, go to SETTLE with settle counter=0.
REQ-006 start SHALL be ignored in SETTLE, CHECK and DONE; exp_table changes after the latch edge SHALL have no effect.
REQ-007 SETTLE SHALL last exactly SETTLE_CYCLES cycles, then go to CHECK.
REQ-008 CHECK SHALL last one cycle; at its closing edge gate_y SHALL be compared with latched exp_table[gate_in].
REQ-009 On mismatch, err_count SHALL increment by 1; fail_idx SHALL be loaded with gate_in only if err_count was 0 (first failure kept).
REQ-010 err_count width SHALL be N_IN+1 bits, so 2**N_IN errors are representable without saturation or wrap.
REQ-011 After CHECK: if gate_in = 2**N_IN-1, the FSM SHALL go to DONE; otherwise gate_in SHALL increment by 1 and the FSM SHALL return to SETTLE with counter=0.
REQ-012 Latency: done SHALL be high during the cycle starting 2**N_IN*(SETTLE_CYCLES+1) edges after the start-sampling edge (12 for defaults).
REQ-013 DONE SHALL last one cycle with done=1 and busy=0, then return to IDLE unconditionally.
REQ-014 pass SHALL be set to (err_count==0, including the final check) on entry to DONE and held until the next accepted start or reset.
REQ-015 gate_in, err_count and fail_idx SHALL hold their values in DONE and IDLE until the next accepted start.
REQ-016 abort=1 in SETTLE or CHECK SHALL move the FSM to IDLE at that edge; busy=0 next cycle, done not pulsed, pass=0, and the CHECK comparison of that edge discarded.
REQ-017 abort SHALL have no effect in IDLE or DONE.
REQ-018 If abort and rst are both high, rst SHALL take priority.

Reset
REQ-019 rst=1 at any edge, in any state (including mid-sweep), SHALL force IDLE and set gate_in=0, busy=0, done=0, pass=0, err_count=0, fail_idx=0 and settle counter=0.
REQ-020 start sampled in the same cycle as rst SHALL be ignored; the first sweep SHALL start no earlier than the first edge with rst=0.

Verification
REQ-021 Reset: assert rst for 2 cycles from random state -> all outputs 0, FSM idle, no done pulse.
REQ-022 Good NOT gate (gate_y=~gate_in[0]), exp_table=4'b0101, defaults, start pulse -> gate_in steps 0,1,2,3 each held 3 cycles; done at edge 12; pass=1; err_count=0; fail_idx=0.
REQ-023 Stuck-at-0 gate_y, exp_table=4'b0101 -> err_count=2, fail_idx=0, pass=0, done at edge 12.
REQ-024 start held high throughout -> sweeps run back-to-back; start pulses mid-sweep do not restart; exactly one IDLE cycle between a done pulse and the next busy=1.
REQ-025 abort during SETTLE of vector 2 -> busy=0 next cycle, no done, pass=0; a following start sweeps from vector 0 with cleared counts.
REQ-026 rst during CHECK of vector 3 with a pending mismatch -> err_count=0, no done; SETTLE_CYCLES=1 run completes at edge 8.
